fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the RISC-V core.
- Owns the program counter and drives the address of the combinational-read instruction memory (instr_mem).
- Buffers fetched words with their PCs in a small FIFO and hands them to decode over a valid/ready handshake.
- Handles branch/jump redirects, flushes, decode back-pressure and misaligned-target faults.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_buf.sv | 73 +++++++
 rtl/fetch_ctrl.sv | 105 ++++++++++
 tb/tb_fetch_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch sequencer
package fetch_pkg;

  localparam int          INSTR_W   = 32;
  localparam int          PC_INC    = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_buf.sv
// rtl/fetch_buf.sv - small synchronous FIFO of {pc, instr} entries; flush beats push and pop
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic               push_i,
  input  logic [PC_W-1:0]    push_pc_i,
  input  logic [INSTR_W-1:0] push_instr_i,
  input  logic               pop_i,
  output logic               full_o,
  output logic               empty_o,
  output logic [PC_W-1:0]    head_pc_o,
  output logic [INSTR_W-1:0] head_instr_o
);

  localparam int AW = $clog2(DEPTH);

  logic [PC_W-1:0]    pc_mem_q    [DEPTH];
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic [AW-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]        cnt_q, cnt_d;
  logic               do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A full buffer can still accept a word when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      if (do_push && !do_pop)      cnt_d = cnt_q + (AW+1)'(1);
      else if (do_pop && !do_push) cnt_d = cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush_i && do_push) begin
      pc_mem_q[wr_q]    <= push_pc_i;
      instr_mem_q[wr_q] <= push_instr_i;
    end
  end

  assign head_pc_o    = empty_o ? '0 : pc_mem_q[rd_q];
  assign head_instr_o = empty_o ? '0 : instr_mem_q[rd_q];

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - PC sequencer feeding a combinational instr_mem and a decode handshake
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_en,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               fetch_err,
  output logic [31:0]        fetch_count
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            err_q, err_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            buf_full, buf_empty, pop, misaligned;

  assign misaligned = |redirect_pc[1:0];
  // A redirect swallows any pop offered in the same cycle.
  assign pop        = out_valid && out_ready && !redirect_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= BOOT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = misaligned ? HALT : RUN;
    end else begin
      case (state_q)
        BOOT:    state_d = RUN;
        RUN:     state_d = RUN;
        HALT:    state_d = HALT;
        default: state_d = BOOT;
      endcase
    end
  end

  always_comb begin
    imem_en = 1'b0;
    if (state_q == RUN && !redirect_valid) imem_en = !buf_full || pop;
  end

  always_comb begin
    pc_d  = pc_q;
    err_d = err_q;
    cnt_d = cnt_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
      if (misaligned) err_d = 1'b1;
    end else if (imem_en) begin
      pc_d = pc_q + PC_W'(PC_INC);
    end
    if (pop) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  fetch_buf #(
    .PC_W  (PC_W),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (redirect_valid),
    .push_i       (imem_en),
    .push_pc_i    (pc_q),
    .push_instr_i (imem_rdata),
    .pop_i        (pop),
    .full_o       (buf_full),
    .empty_o      (buf_empty),
    .head_pc_o    (out_pc),
    .head_instr_o (out_instr)
  );

  assign out_valid   = !buf_empty;
  assign imem_addr   = pc_q;
  assign fetch_err   = err_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_err;
  logic [31:0] fetch_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h0010_0113;
      32'h8:   return 32'h0020_81b3;
      default: return a ^ 32'h1234_5013;
    endcase
  endfunction

  assign imem_rdata = imem_word(imem_addr);

  fetch_ctrl #(
    .PC_W      (32),
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_en        (imem_en),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_err      (fetch_err),
    .fetch_count    (fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then let inputs change away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    tick(); tick(); settle();
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_en",    {31'b0, imem_en},   32'd0);
    chk("rst_err",   {31'b0, fetch_err}, 32'd0);
    chk("rst_cnt",   fetch_count,        32'd0);
    chk("rst_addr",  imem_addr,          32'h0);
    chk("rst_pc",    out_pc,             32'h0);
    chk("rst_instr", out_instr,          32'h0);

    // 1: streaming from reset
    rst_n = 1'b1; settle();
    chk("t1_boot_en",    {31'b0, imem_en},   32'd0);
    chk("t1_boot_valid", {31'b0, out_valid}, 32'd0);
    tick();
    chk("t1_run_en",    {31'b0, imem_en},   32'd1);
    chk("t1_run_valid", {31'b0, out_valid}, 32'd0);
    tick();
    chk("t1_first_valid", {31'b0, out_valid}, 32'd1);
    chk("t1_pc0",    out_pc,    32'h0);
    chk("t1_instr0", out_instr, 32'h0050_0093);
    tick();
    chk("t1_pc4",    out_pc,    32'h4);
    chk("t1_instr4", out_instr, 32'h0010_0113);
    tick();
    chk("t1_pc8",    out_pc,    32'h8);
    tick();
    chk("t1_count3", fetch_count, 32'd3);

    // 2: back-pressure from reset
    rst_n = 1'b0; out_ready = 1'b0;
    tick(); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    settle();
    chk("t2_en_full", {31'b0, imem_en},   32'd0);
    chk("t2_addr",    imem_addr,          32'h8);
    chk("t2_head",    out_pc,             32'h0);
    chk("t2_valid",   {31'b0, out_valid}, 32'd1);
    out_ready = 1'b1; settle();
    chk("t2_en_fullpop", {31'b0, imem_en}, 32'd1);
    chk("t2_pc0", out_pc, 32'h0);
    tick();
    chk("t2_pc4", out_pc, 32'h4);
    tick();
    chk("t2_pc8",  out_pc,      32'h8);
    chk("t2_cnt2", fetch_count, 32'd2);

    // 3: redirect while full
    out_ready = 1'b0;
    tick(); settle();
    chk("t3_full_addr", imem_addr, 32'h10);
    redirect_valid = 1'b1; redirect_pc = 32'h40; out_ready = 1'b1; settle();
    chk("t3_redir_en", {31'b0, imem_en}, 32'd0);
    tick(); redirect_valid = 1'b0; settle();
    chk("t3_r1_valid", {31'b0, out_valid}, 32'd0);
    chk("t3_r1_cnt",   fetch_count,        32'd2);
    chk("t3_r1_addr",  imem_addr,          32'h40);
    tick();
    chk("t3_r2_valid", {31'b0, out_valid}, 32'd1);
    chk("t3_pc40",     out_pc,             32'h40);
    chk("t3_instr40",  out_instr,          imem_word(32'h40));
    tick();
    chk("t3_pc44", out_pc,      32'h44);
    chk("t3_cnt3", fetch_count, 32'd3);

    // 4: misaligned redirect, HALT, recover
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    tick(); redirect_valid = 1'b0; settle();
    chk("t4_err",   {31'b0, fetch_err}, 32'd1);
    chk("t4_valid", {31'b0, out_valid}, 32'd0);
    chk("t4_en",    {31'b0, imem_en},   32'd0);
    chk("t4_addr",  imem_addr,          32'h42);
    redirect_valid = 1'b1; redirect_pc = 32'h43;
    tick(); redirect_valid = 1'b0; tick();
    chk("t4_halt_en",    {31'b0, imem_en},   32'd0);
    chk("t4_halt_valid", {31'b0, out_valid}, 32'd0);
    chk("t4_halt_addr",  imem_addr,          32'h43);
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick(); redirect_valid = 1'b0; settle();
    chk("t4_run_en",  {31'b0, imem_en},   32'd1);
    chk("t4_run_err", {31'b0, fetch_err}, 32'd1);
    tick();
    chk("t4_pc80", out_pc, 32'h80);

    // 5: PC wrap
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick(); redirect_valid = 1'b0; tick();
    chk("t5_pcf8", out_pc, 32'hFFFF_FFF8);
    tick();
    chk("t5_pcfc",    out_pc,    32'hFFFF_FFFC);
    chk("t5_instrfc", out_instr, imem_word(32'hFFFF_FFFC));
    chk("t5_addr0",   imem_addr, 32'h0);
    tick();
    chk("t5_pc0",    out_pc,    32'h0);
    chk("t5_instr0", out_instr, 32'h0050_0093);

    // 6: reset with two entries buffered
    out_ready = 1'b0;
    tick(); tick();
    chk("t6_full_en", {31'b0, imem_en}, 32'd0);
    rst_n = 1'b0;
    tick(); rst_n = 1'b1; settle();
    chk("t6_valid", {31'b0, out_valid}, 32'd0);
    chk("t6_addr",  imem_addr,          32'h0);
    chk("t6_cnt",   fetch_count,        32'd0);
    chk("t6_err",   {31'b0, fetch_err}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
